// File: rtl/data_mem_arbiter_if.sv
// ============================================================================
// data_mem_arbiter_if
// ----------------------------------------------------------------------------
// Bundle of every bus signal around the data-memory arbiter: the two requester
// handshakes (CPU load/store path = requester 0, I/O/DMA path = requester 1),
// the single-port memory connection and the busy status flag.
//
// Modports
//   slave  : the arbiter itself (takes requests, drives acks and the memory)
//   master : the environment (requesters plus the memory array)
//
// Signals (per requester n = 0,1)
//   reqn     request, held until ackn
//   wen      1 = write, 0 = read
//   addrn    word address
//   wdatan   write data
//   ackn     one-cycle completion pulse
//   errn     out-of-range flag, valid with ackn
//   rdatan   read data, valid with ackn, held until the next ackn
// Memory side
//   mem_address, mem_data_in, mem_write_enable  arbiter -> memory
//   mem_data_out                                 memory  -> arbiter
//   busy                                         arbiter not idle
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // requester 0
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              err0;
    logic [DATA_W-1:0] rdata0;

    // requester 1
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic              err1;
    logic [DATA_W-1:0] rdata1;

    // memory port
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_out;

    // status
    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output ack0, err0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, err1, rdata1,
        output mem_address, mem_data_in, mem_write_enable,
        input  mem_data_out,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  ack0, err0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, err1, rdata1,
        input  mem_address, mem_data_in, mem_write_enable,
        output mem_data_out,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter
// ----------------------------------------------------------------------------
// Two-requester arbiter and sequencer in front of a single-port data memory
// (combinational read, write on rising clk). Accesses are serialised through a
// three-state sequencer IDLE -> ACCESS -> ACK, so at most one access is in
// flight and each takes three cycles minimum. Simultaneous requests are
// resolved round-robin; out-of-range addresses (>= DEPTH) never write memory
// and complete with err set and zero read data.
//
// Ports
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    data_mem_arbiter_if.slave: requester handshakes, memory port, busy
// ============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_arbiter_if.slave     bus
);

    localparam int          N_REQ   = 2;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Requester inputs gathered into indexable form
    // ------------------------------------------------------------------------
    logic [N_REQ-1:0]  req_vec;
    logic [N_REQ-1:0]  we_vec;
    logic [ADDR_W-1:0] addr_vec  [N_REQ];
    logic [DATA_W-1:0] wdata_vec [N_REQ];

    assign req_vec      = {bus.req1, bus.req0};
    assign we_vec       = {bus.we1,  bus.we0};
    assign addr_vec[0]  = bus.addr0;
    assign addr_vec[1]  = bus.addr1;
    assign wdata_vec[0] = bus.wdata0;
    assign wdata_vec[1] = bus.wdata1;

    // ------------------------------------------------------------------------
    // Sequencer state and latched access fields
    // ------------------------------------------------------------------------
    state_t            state_q;
    logic              prio_q;    // requester that wins the next tie
    logic              owner_q;   // requester owning the current access
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Per-requester completion registers
    logic              ack_q   [N_REQ];
    logic              err_q   [N_REQ];
    logic [DATA_W-1:0] rdata_q [N_REQ];

    // ------------------------------------------------------------------------
    // Grant decision (only consumed in IDLE)
    // ------------------------------------------------------------------------
    logic grant_valid_d;
    logic grant_sel_d;

    always_comb begin
        grant_valid_d = |req_vec;
        // A lone request wins outright; a tie goes to the priority holder.
        if (&req_vec) begin
            grant_sel_d = prio_q;
        end else begin
            grant_sel_d = req_vec[1];
        end
    end

    // Range check is done on the latched address so it is stable for the
    // whole ACCESS cycle. Comparison is widened to 32 bits so a DEPTH equal
    // to 2**ADDR_W still works.
    logic in_range;
    assign in_range = (32'(addr_q) < DEPTH_W);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        owner_q <= grant_sel_d;
                        we_q    <= we_vec[grant_sel_d];
                        addr_q  <= addr_vec[grant_sel_d];
                        wdata_q <= wdata_vec[grant_sel_d];
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Out-of-range accesses still count as a grant here.
                    prio_q  <= ~owner_q;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    // Requests are deliberately not looked at in this cycle:
                    // the owner is still deasserting its req.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-requester ack / err / read-data registers
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic is_owner_access;
            assign is_owner_access = (state_q == ST_ACCESS) && (owner_q == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_q[gi]   <= 1'b0;
                    err_q[gi]   <= 1'b0;
                    rdata_q[gi] <= '0;
                end else if (is_owner_access) begin
                    ack_q[gi]   <= 1'b1;
                    err_q[gi]   <= ~in_range;
                    // Captured on writes as well (old memory contents); a
                    // requester only looks at it for reads.
                    rdata_q[gi] <= in_range ? bus.mem_data_out : '0;
                end else begin
                    // ack/err are single-cycle; rdata holds until the next ack.
                    ack_q[gi]   <= 1'b0;
                    err_q[gi]   <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.ack0   = ack_q[0];
    assign bus.err0   = err_q[0];
    assign bus.rdata0 = rdata_q[0];
    assign bus.ack1   = ack_q[1];
    assign bus.err1   = err_q[1];
    assign bus.rdata1 = rdata_q[1];

    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;

    // Built only from registered state, so it cannot pulse outside ACCESS and
    // it falls as soon as rst_n clears state_q, killing an in-flight write.
    assign bus.mem_write_enable = (state_q == ST_ACCESS) && we_q && in_range;

    assign bus.busy = (state_q != ST_IDLE);

endmodule
